// File: rtl/sc_ulpi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_ulpi_pkg
// Description : Shared ULPI register-access constants, FSM state encoding and
//               a small bus-ownership helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_ulpi_pkg;

   localparam logic [1:0] ccdRegWrite = 2'b10;
   localparam logic [1:0] ccdRegRead  = 2'b11;
   localparam logic [5:0] cpdExtAddr  = 6'h2F;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_TXCMD   = 4'd1,
      ST_EXTADDR = 4'd2,
      ST_WRDATA  = 4'd3,
      ST_STOP    = 4'd4,
      ST_RDTURN  = 4'd5,
      ST_RDDATA  = 4'd6,
      ST_RDEND   = 4'd7,
      ST_ABTWAIT = 4'd8,
      ST_DONE    = 4'd9
   } ulpi_state_e;

   // States in which the link owns the data bus.
   function automatic logic link_drives(input ulpi_state_e s);
      return (s == ST_TXCMD) || (s == ST_EXTADDR) ||
             (s == ST_WRDATA) || (s == ST_STOP);
   endfunction

endpackage : sc_ulpi_pkg
`default_nettype wire

// File: rtl/sc_ulpi_regif_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_ulpi_regif_if
// Description : ULPI PHY-side bus bundle; master is the link, slave the PHY.
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_ulpi_regif_if;

   logic       dir;
   logic       nxt;
   logic       stp;
   logic       data_oe;
   logic [7:0] data_i;
   logic [7:0] data_o;

   modport master (
      input  dir, nxt, data_i,
      output data_o, data_oe, stp
   );

   modport slave (
      output dir, nxt, data_i,
      input  data_o, data_oe, stp
   );

endinterface : sc_ulpi_regif_if
`default_nettype wire

// File: rtl/sc_ulpi_regif.sv
`default_nettype none
// ============================================================================
// Module      : sc_ulpi_regif
// Description : ULPI link-side register read/write engine with abort/retry
//               handling and RX CMD capture.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_ulpi_regif
   import sc_ulpi_pkg::*;
#(
   parameter int MAX_RETRY = 15
) (
   input  wire logic       ULPICLK,
   input  wire logic       ULPIRST,
   input  wire logic       REG_REQ,
   output logic            REG_ACK,
   output logic            REG_ERR,
   input  wire logic [1:0] REG_CCD,
   input  wire logic [5:0] REG_CPD,
   input  wire logic [7:0] REG_EXT_ADDR,
   input  wire logic [7:0] REG_TX_DATA,
   output logic [7:0]      REG_RX_DATA,
   output logic            RXCMD_VALID,
   output logic [7:0]      RXCMD,
   input  wire logic       ULPI_DIR,
   input  wire logic       ULPI_NXT,
   input  wire logic [7:0] ULPI_DATA_I,
   output logic [7:0]      ULPI_DATA_O,
   output logic            ULPI_DATA_OE,
   output logic            ULPI_STP
);

   // One spare count above MAX_RETRY marks the failing abort.
   localparam int RW = $clog2(MAX_RETRY + 2);

   ulpi_state_e state_q, state_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [1:0]    ccd_q, ccd_d;
   logic [5:0]    cpd_q, cpd_d;
   logic [7:0]    ext_q, ext_d;
   logic [7:0]    txd_q, txd_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic [7:0]    rxcmd_q, rxcmd_d;
   logic [7:0]    data_o_q, data_o_d;
   logic          rxcmd_valid_q, rxcmd_valid_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          stp_q, stp_d;
   logic          dir_prev_q, dir_prev_d;
   logic          retry_exhausted;
   logic          is_read;

   assign retry_exhausted = (retry_q > RW'(MAX_RETRY));
   assign is_read         = (ccd_q == ccdRegRead);

   always_comb begin
      state_d       = state_q;
      retry_d       = retry_q;
      ccd_d         = ccd_q;
      cpd_d         = cpd_q;
      ext_d         = ext_q;
      txd_d         = txd_q;
      rx_data_d     = rx_data_q;
      rxcmd_d       = rxcmd_q;
      rxcmd_valid_d = 1'b0;
      dir_prev_d    = ULPI_DIR;

      case (state_q)
         ST_IDLE: begin
            if (REG_REQ && !ULPI_DIR && !dir_prev_q && !ack_q) begin
               state_d = ST_TXCMD;
               retry_d = '0;
               ccd_d   = REG_CCD;
               cpd_d   = REG_CPD;
               ext_d   = REG_EXT_ADDR;
               txd_d   = REG_TX_DATA;
            end
         end
         // DIR is tested before NXT so a simultaneous abort always wins.
         ST_TXCMD: begin
            if (ULPI_DIR) begin
               state_d = ST_ABTWAIT;
               retry_d = retry_q + RW'(1);
            end else if (ULPI_NXT) begin
               if (cpd_q == cpdExtAddr) state_d = ST_EXTADDR;
               else if (is_read)        state_d = ST_RDTURN;
               else                     state_d = ST_WRDATA;
            end
         end
         ST_EXTADDR: begin
            if (ULPI_DIR) begin
               state_d = ST_ABTWAIT;
               retry_d = retry_q + RW'(1);
            end else if (ULPI_NXT) begin
               state_d = is_read ? ST_RDTURN : ST_WRDATA;
            end
         end
         ST_WRDATA: begin
            if (ULPI_DIR) begin
               state_d = ST_ABTWAIT;
               retry_d = retry_q + RW'(1);
            end else if (ULPI_NXT) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: state_d = ST_DONE;
         ST_RDTURN: begin
            if (ULPI_DIR && ULPI_NXT) begin
               state_d = ST_ABTWAIT;
               retry_d = retry_q + RW'(1);
            end else if (ULPI_DIR) begin
               state_d = ST_RDDATA;
            end
         end
         ST_RDDATA: begin
            rx_data_d = ULPI_DATA_I;
            state_d   = ST_RDEND;
         end
         ST_RDEND: begin
            if (!ULPI_DIR) state_d = ST_DONE;
         end
         // Leave only after DIR has been low for the turnaround cycle too.
         ST_ABTWAIT: begin
            if (!ULPI_DIR && !dir_prev_q)
               state_d = retry_exhausted ? ST_DONE : ST_TXCMD;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (ULPI_DIR && !ULPI_NXT && dir_prev_q &&
          (state_q == ST_IDLE || state_q == ST_ABTWAIT)) begin
         rxcmd_d       = ULPI_DATA_I;
         rxcmd_valid_d = 1'b1;
      end

      ack_d = (state_d == ST_DONE);
      err_d = (state_q == ST_ABTWAIT) && (state_d == ST_DONE);
      stp_d = (state_d == ST_STOP);

      case (state_d)
         ST_TXCMD:   data_o_d = {ccd_d, cpd_d};
         ST_EXTADDR: data_o_d = ext_d;
         ST_WRDATA:  data_o_d = txd_d;
         default:    data_o_d = 8'h00;
      endcase
   end

   always_ff @(posedge ULPICLK) begin
      if (ULPIRST) begin
         state_q       <= ST_IDLE;
         retry_q       <= '0;
         ccd_q         <= '0;
         cpd_q         <= '0;
         ext_q         <= '0;
         txd_q         <= '0;
         rx_data_q     <= '0;
         rxcmd_q       <= '0;
         rxcmd_valid_q <= 1'b0;
         ack_q         <= 1'b0;
         err_q         <= 1'b0;
         stp_q         <= 1'b0;
         data_o_q      <= '0;
         dir_prev_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         retry_q       <= retry_d;
         ccd_q         <= ccd_d;
         cpd_q         <= cpd_d;
         ext_q         <= ext_d;
         txd_q         <= txd_d;
         rx_data_q     <= rx_data_d;
         rxcmd_q       <= rxcmd_d;
         rxcmd_valid_q <= rxcmd_valid_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
         stp_q         <= stp_d;
         data_o_q      <= data_o_d;
         dir_prev_q    <= dir_prev_d;
      end
   end

   assign REG_ACK      = ack_q;
   assign REG_ERR      = err_q;
   assign REG_RX_DATA  = rx_data_q;
   assign RXCMD_VALID  = rxcmd_valid_q;
   assign RXCMD        = rxcmd_q;
   assign ULPI_DATA_O  = data_o_q;
   assign ULPI_STP     = stp_q;
   assign ULPI_DATA_OE = link_drives(state_q) & ~ULPI_DIR;

endmodule : sc_ulpi_regif
`default_nettype wire

// File: tb/tb_sc_ulpi_regif.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_ulpi_regif
// Description : Directed self-checking bench for sc_ulpi_regif.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_ulpi_regif;

   logic       clk;
   logic       rst;
   logic       req;
   logic       ack;
   logic       err;
   logic [1:0] ccd;
   logic [5:0] cpd;
   logic [7:0] ext_addr;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rxcmd_valid;
   logic [7:0] rxcmd;

   int total;
   int bad;

   sc_ulpi_regif_if u_bus ();

   sc_ulpi_regif #(.MAX_RETRY(15)) u_dut (
      .ULPICLK      (clk),
      .ULPIRST      (rst),
      .REG_REQ      (req),
      .REG_ACK      (ack),
      .REG_ERR      (err),
      .REG_CCD      (ccd),
      .REG_CPD      (cpd),
      .REG_EXT_ADDR (ext_addr),
      .REG_TX_DATA  (tx_data),
      .REG_RX_DATA  (rx_data),
      .RXCMD_VALID  (rxcmd_valid),
      .RXCMD        (rxcmd),
      .ULPI_DIR     (u_bus.dir),
      .ULPI_NXT     (u_bus.nxt),
      .ULPI_DATA_I  (u_bus.data_i),
      .ULPI_DATA_O  (u_bus.data_o),
      .ULPI_DATA_OE (u_bus.data_oe),
      .ULPI_STP     (u_bus.stp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; ccd = 2'b00; cpd = 6'h00; ext_addr = 8'h00; tx_data = 8'h00;
      u_bus.dir = 1'b0; u_bus.nxt = 1'b0; u_bus.data_i = 8'h00;
      tick(); tick();
      total++;
      if ({ack, err, rxcmd_valid, u_bus.stp, u_bus.data_oe} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 00000", {ack, err, rxcmd_valid, u_bus.stp, u_bus.data_oe});
      end
      total++;
      if ({u_bus.data_o, rx_data, rxcmd} !== 24'h0) begin
         bad++; $display("FAIL reset_data: got %h want 000000", {u_bus.data_o, rx_data, rxcmd});
      end
      rst = 1'b0;
      tick(); tick();
   endtask

   task automatic test_write();
      ccd = 2'b10; cpd = 6'h04; tx_data = 8'h45; req = 1'b1;
      tick();
      total++;
      if ({u_bus.data_oe, u_bus.data_o} !== {1'b1, 8'h84}) begin
         bad++; $display("FAIL wr_txcmd: got oe=%b data=%h want oe=1 data=84", u_bus.data_oe, u_bus.data_o);
      end
      u_bus.nxt = 1'b1;
      tick();
      total++;
      if (u_bus.data_o !== 8'h45) begin
         bad++; $display("FAIL wr_data: got %h want 45", u_bus.data_o);
      end
      tick();
      u_bus.nxt = 1'b0;
      total++;
      if ({u_bus.stp, u_bus.data_o, ack} !== {1'b1, 8'h00, 1'b0}) begin
         bad++; $display("FAIL wr_stop: got stp=%b data=%h ack=%b want stp=1 data=00 ack=0", u_bus.stp, u_bus.data_o, ack);
      end
      tick();
      total++;
      if ({ack, err, u_bus.stp} !== 3'b100) begin
         bad++; $display("FAIL wr_ack: got ack=%b err=%b stp=%b want 1 0 0", ack, err, u_bus.stp);
      end
      req = 1'b0;
      tick();
      total++;
      if (ack !== 1'b0) begin
         bad++; $display("FAIL wr_ack_pulse: got ack=%b want 0", ack);
      end
      tick();
   endtask

   task automatic test_read();
      ccd = 2'b11; cpd = 6'h0A; req = 1'b1;
      tick();
      total++;
      if (u_bus.data_o !== 8'hCA) begin
         bad++; $display("FAIL rd_txcmd: got %h want CA", u_bus.data_o);
      end
      u_bus.nxt = 1'b1;
      tick();
      u_bus.nxt = 1'b0; u_bus.dir = 1'b1; u_bus.data_i = 8'hEE;
      #1;
      total++;
      if (u_bus.data_oe !== 1'b0) begin
         bad++; $display("FAIL rd_turn_oe: got %b want 0", u_bus.data_oe);
      end
      tick();
      u_bus.data_i = 8'h66;
      tick();
      u_bus.dir = 1'b0; u_bus.data_i = 8'h00;
      total++;
      if ({rx_data, ack} !== {8'h66, 1'b0}) begin
         bad++; $display("FAIL rd_capture: got rx=%h ack=%b want rx=66 ack=0", rx_data, ack);
      end
      tick();
      total++;
      if ({ack, err, rx_data} !== {1'b1, 1'b0, 8'h66}) begin
         bad++; $display("FAIL rd_ack: got ack=%b err=%b rx=%h want 1 0 66", ack, err, rx_data);
      end
      req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_ext_write();
      ccd = 2'b10; cpd = 6'h2F; ext_addr = 8'h81; tx_data = 8'h5A; req = 1'b1;
      tick();
      u_bus.nxt = 1'b1;
      total++;
      if (u_bus.data_o !== 8'hAF) begin
         bad++; $display("FAIL ext_txcmd: got %h want AF", u_bus.data_o);
      end
      tick();
      total++;
      if (u_bus.data_o !== 8'h81) begin
         bad++; $display("FAIL ext_addr: got %h want 81", u_bus.data_o);
      end
      tick();
      total++;
      if (u_bus.data_o !== 8'h5A) begin
         bad++; $display("FAIL ext_data: got %h want 5A", u_bus.data_o);
      end
      tick();
      u_bus.nxt = 1'b0;
      total++;
      if ({u_bus.stp, u_bus.data_o} !== {1'b1, 8'h00}) begin
         bad++; $display("FAIL ext_stop: got stp=%b data=%h want 1 00", u_bus.stp, u_bus.data_o);
      end
      tick();
      total++;
      if ({ack, err} !== 2'b10) begin
         bad++; $display("FAIL ext_ack: got ack=%b err=%b want 1 0", ack, err);
      end
      req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_abort_retry();
      ccd = 2'b10; cpd = 6'h05; tx_data = 8'h33; req = 1'b1;
      tick();
      u_bus.nxt = 1'b1;
      tick();
      total++;
      if (u_bus.data_o !== 8'h33) begin
         bad++; $display("FAIL abt_wrdata: got %h want 33", u_bus.data_o);
      end
      // Abort coincides with NXT on the final byte.
      u_bus.dir = 1'b1;
      #1;
      total++;
      if (u_bus.data_oe !== 1'b0) begin
         bad++; $display("FAIL abt_oe_drop: got %b want 0", u_bus.data_oe);
      end
      tick();
      u_bus.nxt = 1'b0; u_bus.data_i = 8'h4D;
      total++;
      if (u_bus.stp !== 1'b0) begin
         bad++; $display("FAIL abt_no_stp: got %b want 0", u_bus.stp);
      end
      tick();
      u_bus.dir = 1'b0; u_bus.data_i = 8'h00;
      total++;
      if ({rxcmd_valid, rxcmd} !== {1'b1, 8'h4D}) begin
         bad++; $display("FAIL abt_rxcmd: got valid=%b rxcmd=%h want 1 4D", rxcmd_valid, rxcmd);
      end
      tick();
      total++;
      if ({rxcmd_valid, u_bus.data_oe} !== 2'b00) begin
         bad++; $display("FAIL abt_turnaround: got valid=%b oe=%b want 0 0", rxcmd_valid, u_bus.data_oe);
      end
      tick();
      total++;
      if ({u_bus.data_oe, u_bus.data_o} !== {1'b1, 8'h85}) begin
         bad++; $display("FAIL abt_restart: got oe=%b data=%h want 1 85", u_bus.data_oe, u_bus.data_o);
      end
      u_bus.nxt = 1'b1;
      tick(); tick();
      u_bus.nxt = 1'b0;
      tick();
      total++;
      if ({ack, err} !== 2'b10) begin
         bad++; $display("FAIL abt_ack: got ack=%b err=%b want 1 0", ack, err);
      end
      req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_retry_limit();
      ccd = 2'b10; cpd = 6'h04; tx_data = 8'h11; req = 1'b1;
      tick();
      cpd = 6'h00;
      for (int k = 1; k <= 16; k++) begin
         u_bus.dir = 1'b1;
         tick();
         u_bus.dir = 1'b0;
         tick(); tick();
         if (k < 16) begin
            total++;
            if ({ack, u_bus.data_o} !== {1'b0, 8'h84}) begin
               bad++; $display("FAIL retry_%0d: got ack=%b data=%h want 0 84", k, ack, u_bus.data_o);
            end
         end
      end
      total++;
      if ({ack, err} !== 2'b11) begin
         bad++; $display("FAIL retry_err: got ack=%b err=%b want 1 1", ack, err);
      end
      total++;
      if (rx_data !== 8'h66) begin
         bad++; $display("FAIL retry_rx_kept: got %h want 66", rx_data);
      end
      req = 1'b0;
      tick();
      total++;
      if ({ack, err} !== 2'b00) begin
         bad++; $display("FAIL retry_err_pulse: got ack=%b err=%b want 0 0", ack, err);
      end
      tick();
   endtask

   task automatic test_reset_in_read();
      ccd = 2'b11; cpd = 6'h0A; req = 1'b1;
      tick();
      u_bus.nxt = 1'b1;
      tick();
      u_bus.nxt = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; req = 1'b0;
      total++;
      if ({ack, err, rxcmd_valid, u_bus.stp, u_bus.data_oe} !== 5'b0) begin
         bad++; $display("FAIL rst_rd_ctrl: got %b want 00000", {ack, err, rxcmd_valid, u_bus.stp, u_bus.data_oe});
      end
      total++;
      if ({u_bus.data_o, rx_data, rxcmd} !== 24'h0) begin
         bad++; $display("FAIL rst_rd_data: got %h want 000000", {u_bus.data_o, rx_data, rxcmd});
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (ack !== 1'b0) begin
            bad++; $display("FAIL rst_rd_no_ack: cycle %0d got ack=%b want 0", i, ack);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write();
      test_read();
      test_ext_write();
      test_abort_retry();
      test_retry_limit();
      test_reset_in_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sc_ulpi_regif
`default_nettype wire

// File: doc/sc_ulpi_regif.md
SC_ULPI_REGIF -- requirements
Module: sc_ulpi_regif

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 15, meaning the number of abort-triggered retries allowed before an access is failed.
REQ-002 SHALL have port ULPICLK  input  1  sole clock, 60 MHz ULPI clock, all logic on its rising edge.
REQ-003 SHALL have port ULPIRST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port REG_REQ  input  1  access request, level, held until REG_ACK.
REQ-005 SHALL have port REG_ACK  output  1  one-cycle completion pulse.
REQ-006 SHALL have port REG_ERR  output  1  retry limit exceeded; valid with REG_ACK.
REQ-007 SHALL have port REG_CCD  input  2  command code (write/read).
REQ-008 SHALL have port REG_CPD  input  6  register address.
REQ-009 SHALL have port REG_EXT_ADDR  input  8  extended register address.
REQ-010 SHALL have port REG_TX_DATA  input  8  write data.
REQ-011 SHALL have port REG_RX_DATA  output  8  read data, held until the next read completes.
REQ-012 SHALL have port RXCMD_VALID  output  1  one-cycle pulse, RX CMD captured.
REQ-013 SHALL have port RXCMD  output  8  last RX CMD byte.
REQ-014 SHALL have ports ULPI_DIR, ULPI_NXT  input  1 each  PHY bus direction and next.
REQ-015 SHALL have ports ULPI_DATA_I  input  8; ULPI_DATA_O  output  8; ULPI_DATA_OE  output  1; ULPI_STP  output  1.

Function
REQ-016 SHALL implement the FSM IDLE, TXCMD, EXTADDR, WRDATA, STOP, RDTURN, RDDATA, RDEND, ABTWAIT, DONE.
REQ-017 SHALL, in IDLE, start an access only when REG_REQ=1, ULPI_DIR=0, ULPI_DIR was 0 last cycle, and REG_ACK=0.
REQ-018 SHALL, in TXCMD, drive ULPI_DATA_O={REG_CCD,REG_CPD} and hold it until NXT=1.
REQ-019 SHALL, on NXT=1 in TXCMD, go to EXTADDR if REG_CPD=6'h2F, else to WRDATA for a write or RDTURN for a read.
REQ-020 SHALL, in EXTADDR, drive REG_EXT_ADDR until NXT=1, then go to WRDATA or RDTURN.
REQ-021 SHALL, in WRDATA, drive REG_TX_DATA until NXT=1, then go to STOP.
REQ-022 SHALL, in STOP, assert ULPI_STP=1 and ULPI_DATA_O=8'h00 for exactly one cycle, then go to DONE.
REQ-023 SHALL, in RDTURN, go to RDDATA when DIR=1 and NXT=0; if DIR=1 and NXT=1, treat the access as aborted.
REQ-024 SHALL, in RDDATA, capture ULPI_DATA_I into REG_RX_DATA, then go to RDEND.
REQ-025 SHALL, in RDEND, wait for DIR=0 (turnaround), then go to DONE.
REQ-026 SHALL, in DONE, assert REG_ACK for one cycle, then return to IDLE; write latency with no wait states is TXCMD→ACK in 4 cycles.
REQ-027 SHALL drive ULPI_DATA_OE = (state ∈ {TXCMD, EXTADDR, WRDATA, STOP}) & ~ULPI_DIR, combinationally.
REQ-028 SHALL treat DIR rising in TXCMD, EXTADDR or WRDATA as an abort: go to ABTWAIT, then increment the retry counter.
REQ-029 SHALL, in ABTWAIT, wait for DIR=0 plus one turnaround cycle, then restart at TXCMD.
REQ-030 SHALL, when the retry count would exceed MAX_RETRY, go to DONE with REG_ERR=1 and leave REG_RX_DATA unchanged.
REQ-031 SHALL clear the retry counter at every access start.
REQ-032 SHALL, when DIR=1, NXT=0, the previous DIR=1, and the state is IDLE or ABTWAIT, load RXCMD and pulse RXCMD_VALID.
REQ-033 SHALL never treat the turnaround cycle after a DIR edge as data.
REQ-034 SHALL, when an abort and the NXT for the final byte occur in the same cycle, give DIR priority (abort).
REQ-035 SHALL sample REG_CCD, REG_CPD, REG_EXT_ADDR and REG_TX_DATA at access start and hold them for all retries.

Reset
REQ-036 SHALL, while ULPIRST=1, return the FSM to IDLE and set REG_ACK, REG_ERR, RXCMD_VALID, ULPI_STP and ULPI_DATA_OE to 0.
REQ-037 SHALL, while ULPIRST=1, set ULPI_DATA_O, REG_RX_DATA, RXCMD and the retry counter to 0.
REQ-038 SHALL abandon an access interrupted by reset with no REG_ACK issued.

Structure
REQ-039 SHALL take ccdRegWrite=2'b10, ccdRegRead=2'b11, the extended-address CPD 6'h2F and the FSM state enum from sc_ulpi_pkg.
REQ-040 SHALL be one flat module with no sub-module.

Verification
REQ-041 SHALL cover: write CPD=6'h04, data 8'h45, NXT granted immediately → bus shows 84,45,STP with 00, then REG_ACK one cycle later, REG_ERR=0.
REQ-042 SHALL cover: read CPD=6'h0A, PHY returns 8'h66 → TXCMD 8'hCA, turnaround, REG_RX_DATA=8'h66, REG_ACK after DIR falls.
REQ-043 SHALL cover: extended write EXT_ADDR=8'h81, data 8'h5A → bus shows AF,81,5A,STP.
REQ-044 SHALL cover: DIR rises during WRDATA, then PHY sends RX CMD 8'h4D → OE drops the same cycle, RXCMD_VALID with 8'h4D, the access retries and completes.
REQ-045 SHALL cover: 16 consecutive aborts with MAX_RETRY=15 → REG_ACK with REG_ERR=1.
REQ-046 SHALL cover: ULPIRST pulsed during RDTURN → all outputs 0 next cycle, no REG_ACK.
